dmtd_phase_gen: RTL and testbench

DMTD_PHASE_GEN -- requirements
Module: dmtd_phase_gen

---
 rtl/dmtd_phase_gen.sv | 116 +++++++++++
 tb/tb_dmtd_phase_gen.sv | 327 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dmtd_phase_gen.sv
// dmtd_phase_gen: generates two square waves of period 2*HALF_PERIOD clk cycles.
// clk_a is the reference; clk_b is shifted by a programmable offset that is
// loaded through a pending register and applied only at the counter wrap.
// Optional feature macro: DMTD_PHASE_GEN_SWEEP_EN (auto-sweep of the offset).
module dmtd_phase_gen #(
  parameter int unsigned HALF_PERIOD = 64
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       delay_sign,
  input  logic [6:0] delay,
  input  logic       load,
  input  logic       sweep,
  output logic       clk_a,
  output logic       clk_b,
  output logic       busy,
  output logic       err
);

  localparam int unsigned P  = 2 * HALF_PERIOD;
  localparam int unsigned CW = 8;
  localparam int unsigned DW = CW + 1;
  localparam logic [CW-1:0] LAST   = CW'(P - 1);
  localparam logic [DW-1:0] P_EXT  = DW'(P);
  localparam logic [DW-1:0] HP_EXT = DW'(HALF_PERIOD);

  logic [CW-1:0] cnt_q, cnt_d;
  logic [CW-1:0] off_q, off_d;
  logic [CW-1:0] pend_q, pend_d;
  logic          busy_q, busy_d;
  logic          err_q, err_d;
  logic          clk_a_q, clk_a_d;
  logic          clk_b_q, clk_b_d;

  logic          wrap_c;
  logic          legal_c;
  logic [DW-1:0] delay_ext_c;
  logic [DW-1:0] diff_c;
  logic [DW-1:0] phase_b_c;
  logic [CW-1:0] enc_c;

`ifndef DMTD_PHASE_GEN_SWEEP_EN
  logic unused_sweep_c;
  assign unused_sweep_c = sweep;
`endif

  // Wrap detect, load legality, offset encoding and clk_b phase (cnt - offset) mod P
  always_comb begin
    wrap_c      = (cnt_q == LAST);
    delay_ext_c = DW'(delay);
    legal_c     = (delay_ext_c < P_EXT);
    if (delay_sign && (delay != 7'd0)) begin
      enc_c = CW'(P_EXT - delay_ext_c);
    end else begin
      enc_c = CW'(delay);
    end
    diff_c    = DW'(cnt_q) + P_EXT - DW'(off_q);
    phase_b_c = (diff_c >= P_EXT) ? (diff_c - P_EXT) : diff_c;
  end

  // Next-state: counter, output waves, pending/applied offset handoff at the wrap
  always_comb begin
    cnt_d   = wrap_c ? '0 : (cnt_q + CW'(1));
    off_d   = off_q;
    pend_d  = pend_q;
    busy_d  = busy_q;
    clk_a_d = (DW'(cnt_q) < HP_EXT);
    clk_b_d = (phase_b_c < HP_EXT);
    err_d   = load && !legal_c;

    if (wrap_c) begin
      busy_d = 1'b0;
      if (busy_q) begin
        off_d = pend_q;
      end
`ifdef DMTD_PHASE_GEN_SWEEP_EN
      else if (sweep) begin
        off_d = (off_q == LAST) ? '0 : (off_q + CW'(1));
      end
`endif
    end

    // A load in the wrap cycle becomes pending for the following wrap
    if (load && legal_c) begin
      pend_d = enc_c;
      busy_d = 1'b1;
    end
  end

  // State registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q   <= '0;
      off_q   <= '0;
      pend_q  <= '0;
      busy_q  <= 1'b0;
      err_q   <= 1'b0;
      clk_a_q <= 1'b0;
      clk_b_q <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      off_q   <= off_d;
      pend_q  <= pend_d;
      busy_q  <= busy_d;
      err_q   <= err_d;
      clk_a_q <= clk_a_d;
      clk_b_q <= clk_b_d;
    end
  end

  assign clk_a = clk_a_q;
  assign clk_b = clk_b_q;
  assign busy  = busy_q;
  assign err   = err_q;

endmodule

// File: tb/tb_dmtd_phase_gen.sv
// Self-checking bench for dmtd_phase_gen (HALF_PERIOD=64 main instance,
// HALF_PERIOD=32 instance for load rejection).
`timescale 1ns/1ps
module tb_dmtd_phase_gen;

  localparam int HP   = 64;
  localparam int PI   = 2 * HP;
  localparam int HP32 = 32;
  localparam int P32  = 2 * HP32;
`ifdef DMTD_PHASE_GEN_SWEEP_EN
  localparam bit SWEEP_ON = 1'b1;
`else
  localparam bit SWEEP_ON = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst, delay_sign, load, sweep;
  logic [6:0] delay;
  logic       clk_a, clk_b, busy, err;
  logic       clk_a32, clk_b32, busy32, err32;

  int n_pass  = 0;
  int n_total = 0;
  int cyc     = 0;

  // Reference model state (spec-level)
  int m_cnt, m_off, m_pend;
  bit m_busy, m_a, m_b, m_err;
  int k32;
  bit e32;
  int a_rises[$];
  int b_rises[$];
  bit prev_a, prev_b;

  always #5 clk = ~clk;

  dmtd_phase_gen #(.HALF_PERIOD(HP)) dut (
    .clk(clk), .rst(rst), .delay_sign(delay_sign), .delay(delay),
    .load(load), .sweep(sweep), .clk_a(clk_a), .clk_b(clk_b),
    .busy(busy), .err(err)
  );

  dmtd_phase_gen #(.HALF_PERIOD(HP32)) dut32 (
    .clk(clk), .rst(rst), .delay_sign(delay_sign), .delay(delay),
    .load(load), .sweep(sweep), .clk_a(clk_a32), .clk_b(clk_b32),
    .busy(busy32), .err(err32)
  );

  task automatic model_step(input bit r, input bit ld, input bit sg, input int d, input bit sw);
    int ph;
    if (r) begin
      m_cnt = 0; m_off = 0; m_pend = 0;
      m_busy = 1'b0; m_a = 1'b0; m_b = 1'b0; m_err = 1'b0;
      k32 = 0; e32 = 1'b0;
      return;
    end
    ph    = (((m_cnt - m_off) % PI) + PI) % PI;
    m_a   = (m_cnt < HP);
    m_b   = (ph < HP);
    m_err = ld && (d >= PI);
    if (m_cnt == PI - 1) begin
      if (m_busy) m_off = m_pend;
      else if (SWEEP_ON && sw) m_off = (m_off + 1) % PI;
      m_busy = 1'b0;
    end
    if (ld && (d < PI)) begin
      m_pend = sg ? ((PI - d) % PI) : d;
      m_busy = 1'b1;
    end
    m_cnt = (m_cnt + 1) % PI;
    e32   = (k32 < HP32);
    k32   = (k32 + 1) % P32;
  endtask

  task automatic cycle(input bit r, input bit ld, input bit sg, input int d, input bit sw);
    @(negedge clk);
    rst = r; load = ld; delay_sign = sg; delay = 7'(d); sweep = sw;
    @(posedge clk);
    model_step(r, ld, sg, d, sw);
    #1;
    cyc++;
    if (clk_a && !prev_a) a_rises.push_back(cyc);
    if (clk_b && !prev_b) b_rises.push_back(cyc);
    prev_a = clk_a;
    prev_b = clk_b;
  endtask

  task automatic idle_to(input int target);
    for (int i = 0; i < PI && m_cnt != target; i++) cycle(1'b0, 1'b0, 1'b0, 0, 1'b0);
  endtask

  // Skip to a wrap, let one period settle, then record rise offsets over one period
  task automatic measure_period(output int a_off, output int b_off);
    int base;
    idle_to(0);
    for (int i = 0; i < PI; i++) cycle(1'b0, 1'b0, 1'b0, 0, 1'b0);
    a_rises.delete(); b_rises.delete();
    base = cyc;
    for (int i = 0; i < PI; i++) cycle(1'b0, 1'b0, 1'b0, 0, 1'b0);
    a_off = (a_rises.size() > 0) ? a_rises[0] - base : -1;
    b_off = (b_rises.size() > 0) ? b_rises[0] - base : -1;
  endtask

  task automatic test_reset();
    for (int i = 0; i < 5; i++) begin
      cycle(1'b1, 1'b0, 1'b0, 0, 1'b0);
      n_total++;
      if ({clk_a, clk_b, busy, err} !== 4'b0000)
        $display("FAIL reset_outputs cyc=%0d got=%b exp=0000", cyc, {clk_a, clk_b, busy, err});
      else n_pass++;
    end
    cycle(1'b0, 1'b0, 1'b0, 0, 1'b0);
    n_total++;
    if ({clk_a, clk_b} !== 2'b11)
      $display("FAIL reset_first_rise got=%b exp=11", {clk_a, clk_b});
    else n_pass++;
  endtask

  task automatic test_free_run();
    int base;
    int highs;
    for (int i = 0; i < 5; i++) cycle(1'b1, 1'b0, 1'b0, 0, 1'b0);
    base = cyc; highs = 0;
    a_rises.delete(); b_rises.delete();
    for (int i = 0; i < 300; i++) begin
      cycle(1'b0, 1'b0, 1'b0, 0, 1'b0);
      n_total++;
      if ({clk_a, clk_b, busy, err} !== {m_a, m_b, m_busy, m_err})
        $display("FAIL free_run cyc=%0d got=%b exp=%b", cyc, {clk_a, clk_b, busy, err}, {m_a, m_b, m_busy, m_err});
      else n_pass++;
      if (i < PI && clk_a) highs++;
    end
    n_total++;
    if (highs != HP) $display("FAIL free_run_high got=%0d exp=%0d", highs, HP);
    else n_pass++;
    n_total++;
    if (a_rises.size() < 2 || a_rises[0] - base != 1 || a_rises[1] - a_rises[0] != PI)
      $display("FAIL free_run_period rises=%0d first=%0d exp first=1 period=%0d",
               a_rises.size(), (a_rises.size() > 0) ? a_rises[0] - base : -1, PI);
    else n_pass++;
    n_total++;
    if (b_rises.size() < 1 || a_rises.size() < 1 || b_rises[0] != a_rises[0])
      $display("FAIL free_run_align got b_rises=%0d exp aligned with clk_a", b_rises.size());
    else n_pass++;
  endtask

  task automatic test_lag_load();
    int ao, bo;
    cycle(1'b1, 1'b0, 1'b0, 0, 1'b0);
    cycle(1'b1, 1'b0, 1'b0, 0, 1'b0);
    idle_to(30);
    cycle(1'b0, 1'b1, 1'b0, 10, 1'b0);
    n_total++;
    if (busy !== 1'b1) $display("FAIL lag_busy_set got=%b exp=1", busy);
    else n_pass++;
    for (int i = 0; i < PI && m_cnt != 0; i++) begin
      cycle(1'b0, 1'b0, 1'b0, 0, 1'b0);
      n_total++;
      if ({clk_a, clk_b, busy, err} !== {m_a, m_b, m_busy, m_err})
        $display("FAIL lag_pending cyc=%0d got=%b exp=%b", cyc, {clk_a, clk_b, busy, err}, {m_a, m_b, m_busy, m_err});
      else n_pass++;
    end
    n_total++;
    if (busy !== 1'b0) $display("FAIL lag_busy_clear got=%b exp=0", busy);
    else n_pass++;
    measure_period(ao, bo);
    n_total++;
    if (bo - ao != 10) $display("FAIL lag_10 got=%0d exp=10", bo - ao);
    else n_pass++;
  endtask

  task automatic test_lead_overwrite();
    int ao, bo;
    cycle(1'b1, 1'b0, 1'b0, 0, 1'b0);
    idle_to(5);
    cycle(1'b0, 1'b1, 1'b1, 10, 1'b0);
    measure_period(ao, bo);
    n_total++;
    if (bo - ao != PI - 10) $display("FAIL lead_10 got=%0d exp=%0d", bo - ao, PI - 10);
    else n_pass++;
    idle_to(20);
    cycle(1'b0, 1'b1, 1'b1, 20, 1'b0);
    for (int i = 0; i < 10; i++) cycle(1'b0, 1'b0, 1'b0, 0, 1'b0);
    cycle(1'b0, 1'b1, 1'b1, 5, 1'b0);
    n_total++;
    if (busy !== 1'b1) $display("FAIL overwrite_busy got=%b exp=1", busy);
    else n_pass++;
    measure_period(ao, bo);
    n_total++;
    if (bo - ao != PI - 5) $display("FAIL overwrite_lead_5 got=%0d exp=%0d", bo - ao, PI - 5);
    else n_pass++;
  endtask

  task automatic test_wrap_load();
    int ao, bo;
    cycle(1'b1, 1'b0, 1'b0, 0, 1'b0);
    idle_to(50);
    cycle(1'b0, 1'b1, 1'b0, 10, 1'b0);
    idle_to(PI - 1);
    cycle(1'b0, 1'b1, 1'b0, 20, 1'b0);
    n_total++;
    if (busy !== 1'b1) $display("FAIL wrap_load_busy got=%b exp=1", busy);
    else n_pass++;
    for (int i = 0; i < PI; i++) begin
      cycle(1'b0, 1'b0, 1'b0, 0, 1'b0);
      n_total++;
      if ({clk_a, clk_b, busy, err} !== {m_a, m_b, m_busy, m_err})
        $display("FAIL wrap_load cyc=%0d got=%b exp=%b", cyc, {clk_a, clk_b, busy, err}, {m_a, m_b, m_busy, m_err});
      else n_pass++;
    end
    measure_period(ao, bo);
    n_total++;
    if (bo - ao != 20) $display("FAIL wrap_load_lag got=%0d exp=20", bo - ao);
    else n_pass++;
  endtask

  task automatic test_reject();
    cycle(1'b1, 1'b0, 1'b0, 0, 1'b0);
    cycle(1'b1, 1'b0, 1'b0, 0, 1'b0);
    for (int i = 0; i < 3; i++) cycle(1'b0, 1'b0, 1'b0, 0, 1'b0);
    cycle(1'b0, 1'b1, 1'b0, 70, 1'b0);
    n_total++;
    if ({err32, busy32} !== 2'b10) $display("FAIL reject_70 got err,busy=%b exp=10", {err32, busy32});
    else n_pass++;
    cycle(1'b0, 1'b0, 1'b0, 0, 1'b0);
    n_total++;
    if ({err32, busy32} !== 2'b00) $display("FAIL reject_pulse_end got err,busy=%b exp=00", {err32, busy32});
    else n_pass++;
    for (int i = 0; i < 2 * P32; i++) begin
      cycle(1'b0, 1'b0, 1'b0, 0, 1'b0);
      n_total++;
      if ({clk_a32, clk_b32, busy32, err32} !== {e32, e32, 2'b00})
        $display("FAIL reject_phase cyc=%0d got=%b exp=%b", cyc, {clk_a32, clk_b32, busy32, err32}, {e32, e32, 2'b00});
      else n_pass++;
    end
    cycle(1'b0, 1'b1, 1'b1, 64, 1'b0);
    n_total++;
    if ({err32, busy32} !== 2'b10) $display("FAIL reject_64 got err,busy=%b exp=10", {err32, busy32});
    else n_pass++;
    cycle(1'b0, 1'b1, 1'b0, 63, 1'b0);
    n_total++;
    if ({err32, busy32} !== 2'b01) $display("FAIL accept_63 got err,busy=%b exp=01", {err32, busy32});
    else n_pass++;
  endtask

  task automatic test_reset_busy();
    int ao, bo;
    cycle(1'b1, 1'b0, 1'b0, 0, 1'b0);
    idle_to(10);
    cycle(1'b0, 1'b1, 1'b0, 40, 1'b0);
    n_total++;
    if (busy !== 1'b1) $display("FAIL rst_busy_set got=%b exp=1", busy);
    else n_pass++;
    for (int i = 0; i < 2; i++) begin
      cycle(1'b1, 1'b0, 1'b0, 0, 1'b0);
      n_total++;
      if ({clk_a, clk_b, busy, err} !== 4'b0000)
        $display("FAIL rst_busy_outputs got=%b exp=0000", {clk_a, clk_b, busy, err});
      else n_pass++;
    end
    cycle(1'b0, 1'b0, 1'b0, 0, 1'b0);
    n_total++;
    if ({clk_a, clk_b, busy} !== 3'b110) $display("FAIL rst_release got=%b exp=110", {clk_a, clk_b, busy});
    else n_pass++;
    measure_period(ao, bo);
    n_total++;
    if (bo - ao != 0) $display("FAIL rst_discard_lag got=%0d exp=0", bo - ao);
    else n_pass++;
  endtask

  task automatic test_sweep();
    cycle(1'b1, 1'b0, 1'b0, 0, 1'b0);
    a_rises.delete(); b_rises.delete();
    for (int i = 0; i < 5 * PI; i++) begin
      cycle(1'b0, 1'b0, 1'b0, 0, 1'b1);
      n_total++;
      if ({clk_a, clk_b, busy, err} !== {m_a, m_b, m_busy, m_err})
        $display("FAIL sweep cyc=%0d got=%b exp=%b", cyc, {clk_a, clk_b, busy, err}, {m_a, m_b, m_busy, m_err});
      else n_pass++;
    end
    for (int k = 1; k <= 4; k++) begin
      n_total++;
      if (a_rises.size() <= k || b_rises.size() <= k)
        $display("FAIL sweep_lag_%0d got rises a=%0d b=%0d exp>%0d", k, a_rises.size(), b_rises.size(), k);
      else if (b_rises[k] - a_rises[k] != (SWEEP_ON ? k : 0))
        $display("FAIL sweep_lag_%0d got=%0d exp=%0d", k, b_rises[k] - a_rises[k], SWEEP_ON ? k : 0);
      else n_pass++;
    end
  endtask

  task automatic test_random();
    bit r, ld, sg, sw;
    int d;
    cycle(1'b1, 1'b0, 1'b0, 0, 1'b0);
    sw = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 299) == 0) sw = ~sw;
      r  = ($urandom_range(0, 499) == 0);
      ld = ($urandom_range(0, 15) == 0) || (m_cnt == PI - 1 && $urandom_range(0, 1) == 1);
      sg = 1'($urandom_range(0, 1));
      d  = (($urandom_range(0, 9) == 0) ? 0 : int'($urandom_range(0, 127)));
      cycle(r, ld, sg, d, sw);
      n_total++;
      if ({clk_a, clk_b, busy, err} !== {m_a, m_b, m_busy, m_err})
        $display("FAIL random cyc=%0d got=%b exp=%b", cyc, {clk_a, clk_b, busy, err}, {m_a, m_b, m_busy, m_err});
      else n_pass++;
    end
  endtask

  initial begin
    rst = 1'b1; load = 1'b0; delay_sign = 1'b0; delay = 7'd0; sweep = 1'b0;
    prev_a = 1'b0; prev_b = 1'b0;
    model_step(1'b1, 1'b0, 1'b0, 0, 1'b0);
    test_reset();
    test_free_run();
    test_lag_load();
    test_lead_overwrite();
    test_wrap_load();
    test_reject();
    test_reset_busy();
    test_sweep();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
